// File: rtl/stopwatch_fnd_ctrl.sv
// stopwatch_fnd_ctrl: 4-digit multiplexed 7-segment driver showing SS.cc or HH.MM with 1 Hz blinking dp
module stopwatch_fnd_ctrl #(
  parameter int SCAN_COUNT = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] i_msec,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic [4:0] i_hour,
  input  logic       i_disp_sel,
  output logic [3:0] fnd_com,
  output logic [7:0] fnd_data
);
  localparam int CW = $clog2(SCAN_COUNT);
  logic [CW-1:0] r_cnt;
  logic [1:0]    digit_sel;
  logic          r_active;
  logic [6:0]    s_msec;
  logic [5:0]    s_sec;
  logic [5:0]    s_min;
  logic [4:0]    s_hour;
  logic          s_disp_sel;
  logic          scan_tick;
  logic          load;
  logic [3:0]    digit;
  logic          dp_n;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Slot tick at the end of each prescaler period; the snapshot is taken whenever the next digit is 0
  always_comb begin
    scan_tick = (r_cnt == CW'(SCAN_COUNT - 1));
    load      = scan_tick && (!r_active || digit_sel == 2'd3);
  end

  // Prescaler, digit scan position and per-frame snapshot of the time value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      digit_sel  <= '0;
      r_active   <= 1'b0;
      s_msec     <= '0;
      s_sec      <= '0;
      s_min      <= '0;
      s_hour     <= '0;
      s_disp_sel <= 1'b0;
    end else begin
      r_cnt <= scan_tick ? '0 : r_cnt + 1'b1;
      if (scan_tick) begin
        r_active  <= 1'b1;
        digit_sel <= r_active ? digit_sel + 2'd1 : 2'd0;
      end
      if (load) begin
        s_msec     <= i_msec;
        s_sec      <= i_sec;
        s_min      <= i_min;
        s_hour     <= i_hour;
        s_disp_sel <= i_disp_sel;
      end
    end
  end

  // Select the BCD digit for the current slot from the snapshot
  always_comb begin
    digit = '0;
    case (digit_sel)
      2'd0: digit = s_disp_sel ? 4'(s_min % 6'd10)  : 4'(s_msec % 7'd10);
      2'd1: digit = s_disp_sel ? 4'(s_min / 6'd10)  : 4'(s_msec / 7'd10);
      2'd2: digit = s_disp_sel ? 4'(s_hour % 5'd10) : 4'(s_sec % 6'd10);
      2'd3: digit = s_disp_sel ? 4'(s_hour / 5'd10) : 4'(s_sec / 6'd10);
    endcase
  end

  // Drive the display from registered state only; dark until the first slot tick
  always_comb begin
    dp_n     = !(digit_sel == 2'd2 && s_msec < 7'd50);
    fnd_com  = r_active ? ~(4'b0001 << digit_sel) : 4'hF;
    fnd_data = r_active ? {dp_n, seg7(digit)} : 8'hFF;
  end
endmodule

// File: tb/tb_stopwatch_fnd_ctrl.sv
// tb_stopwatch_fnd_ctrl: directed checks of scan timing, digit decode, snapshot coherence and reset
module tb_stopwatch_fnd_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] i_msec = 7'd42;
  logic [5:0] i_sec = 6'd37;
  logic [5:0] i_min = 6'd5;
  logic [4:0] i_hour = 5'd9;
  logic       i_disp_sel = 1'b0;
  logic [3:0] fnd_com;
  logic [7:0] fnd_data;
  int checks = 0;
  int failures = 0;

  stopwatch_fnd_ctrl #(.SCAN_COUNT(4)) dut (
    .clk(clk), .reset(reset), .i_msec(i_msec), .i_sec(i_sec), .i_min(i_min),
    .i_hour(i_hour), .i_disp_sel(i_disp_sel), .fnd_com(fnd_com), .fnd_data(fnd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] com, input logic [7:0] data);
    checks++;
    assert (fnd_com === com) else begin
      failures++;
      $error("FAIL %s com got=%b exp=%b", tag, fnd_com, com);
    end
    checks++;
    assert (fnd_data === data) else begin
      failures++;
      $error("FAIL %s data got=%h exp=%h", tag, fnd_data, data);
    end
  endtask

  task automatic slot(input string tag, input logic [3:0] com, input logic [7:0] data);
    for (int i = 0; i < 4; i++) begin
      chk(tag, com, data);
      @(negedge clk);
    end
  endtask

  task automatic dark_wait(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk(tag, 4'hF, 8'hFF);
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_dark", 4'hF, 8'hFF);
    reset = 1'b0;
    dark_wait("post_reset_dark");
    slot("f1_d0", 4'b1110, 8'hA4);
    slot("f1_d1", 4'b1101, 8'h99);
    slot("f1_d2", 4'b1011, 8'h78);
    slot("f1_d3", 4'b0111, 8'hB0);
    slot("f2_d0", 4'b1110, 8'hA4);
    i_msec = 7'd43;
    i_disp_sel = 1'b1;
    slot("f2_d1_old", 4'b1101, 8'h99);
    slot("f2_d2_old", 4'b1011, 8'h78);
    slot("f2_d3_old", 4'b0111, 8'hB0);
    slot("f3_d0", 4'b1110, 8'h92);
    i_msec = 7'd75;
    slot("f3_d1", 4'b1101, 8'hC0);
    slot("f3_d2_dp", 4'b1011, 8'h10);
    slot("f3_d3", 4'b0111, 8'hC0);
    slot("f4_d0", 4'b1110, 8'h92);
    i_msec = 7'd127;
    i_sec = 6'd63;
    i_disp_sel = 1'b0;
    slot("f4_d1", 4'b1101, 8'hC0);
    slot("f4_d2_nodp", 4'b1011, 8'h90);
    slot("f4_d3", 4'b0111, 8'hC0);
    slot("f5_d0", 4'b1110, 8'hF8);
    slot("f5_d1_blank", 4'b1101, 8'hFF);
    slot("f5_d2", 4'b1011, 8'hB0);
    slot("f5_d3", 4'b0111, 8'h82);
    slot("f6_d0", 4'b1110, 8'hF8);
    slot("f6_d1", 4'b1101, 8'hFF);
    chk("f6_d2_pre", 4'b1011, 8'hB0);
    reset = 1'b1;
    #1;
    chk("async_reset_dark", 4'hF, 8'hFF);
    @(negedge clk);
    chk("held_reset_dark", 4'hF, 8'hFF);
    reset = 1'b0;
    dark_wait("rerelease_dark");
    slot("r_d0", 4'b1110, 8'hF8);
    chk("r_d1", 4'b1101, 8'hFF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
